gestor_llamadas_asc: RTL and testbench

- Request side of the elevator controller interface: latches cabin and hall call buttons, tracks pending calls per floor, and selects the next target floor using a SCAN (sweep) policy.
- Consumes the car status outputs of the elevator FSM (piso, direccion, puertas_abiertas).
- Returns piso_objetivo / objetivo_valido to the elevator FSM and drives the button lamps.

---
 rtl/gestor_llamadas_asc_pkg.sv | 21 ++
 rtl/gestor_llamadas_asc_if.sv | 36 +++
 rtl/gestor_llamadas_asc_detector_flanco.sv | 31 +++
 rtl/gestor_llamadas_asc.sv | 184 ++++++++++++++++++
 tb/tb_gestor_llamadas_asc.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/gestor_llamadas_asc_pkg.sv
// rtl/gestor_llamadas_asc_pkg.sv - shared encodings and defaults for the elevator call manager
// Purpose: car motion encodings, sweep state encoding and default floor count/width.
// Ports: none (package).
package asc_pkg;

  localparam int N_PISOS_DEF = 4;
  localparam int W_PISO_DEF  = 2;

  // Car motion as reported by the elevator FSM
  localparam logic [1:0] DIR_PARADO = 2'b00;
  localparam logic [1:0] DIR_SUBE   = 2'b01;
  localparam logic [1:0] DIR_BAJA   = 2'b10;

  // Sweep state, also exported on sentido_barrido
  typedef enum logic [1:0] {
    REPOSO   = 2'b00,
    SUBIENDO = 2'b01,
    BAJANDO  = 2'b10
  } barrido_e;

endpackage

// File: rtl/gestor_llamadas_asc_if.sv
// rtl/gestor_llamadas_asc_if.sv - button, car status and target bundle for the call manager
// Purpose: groups the buttons, car status inputs and target/lamp outputs.
// Ports (signals):
//   boton_cabina/boton_subir/boton_bajar [N_PISOS] buttons, level
//   piso [W_PISO], direccion [2], puertas_abiertas : car status
//   pendientes [N_PISOS], piso_objetivo [W_PISO], objetivo_valido, sentido_barrido [2] : results
// Modports: slave = call manager, master = button panel / elevator FSM side.
interface gestor_llamadas_asc_if #(
  parameter int N_PISOS = asc_pkg::N_PISOS_DEF,
  parameter int W_PISO  = asc_pkg::W_PISO_DEF
) ();

  logic [N_PISOS-1:0] boton_cabina;
  logic [N_PISOS-1:0] boton_subir;
  logic [N_PISOS-1:0] boton_bajar;
  logic [W_PISO-1:0]  piso;
  logic [1:0]         direccion;
  logic               puertas_abiertas;
  logic [N_PISOS-1:0] pendientes;
  logic [W_PISO-1:0]  piso_objetivo;
  logic               objetivo_valido;
  logic [1:0]         sentido_barrido;

  modport slave (
    input  boton_cabina, boton_subir, boton_bajar,
    input  piso, direccion, puertas_abiertas,
    output pendientes, piso_objetivo, objetivo_valido, sentido_barrido
  );

  modport master (
    output boton_cabina, boton_subir, boton_bajar,
    output piso, direccion, puertas_abiertas,
    input  pendientes, piso_objetivo, objetivo_valido, sentido_barrido
  );

endinterface

// File: rtl/gestor_llamadas_asc_detector_flanco.sv
// rtl/gestor_llamadas_asc_detector_flanco.sv - registered rising-edge detector for button vectors
// Purpose: registers each button once, then flags a 0->1 transition of that registered value.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   d [N]           : raw button levels
//   flanco [N]      : one-cycle pulse per press, aligned to the registered value
module detector_flanco_asc #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  output logic [N-1:0] flanco
);

  logic [N-1:0] d_reg;
  logic [N-1:0] d_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_reg  <= '0;
      d_hist <= '0;
    end else begin
      d_reg  <= d;
      d_hist <= d_reg;
    end
  end

  assign flanco = d_reg & ~d_hist;

endmodule

// File: rtl/gestor_llamadas_asc.sv
// rtl/gestor_llamadas_asc.sv - elevator call latching and SCAN target selection
// Purpose: latches cabin/hall calls, clears the floor being served, runs a
//   REPOSO/SUBIENDO/BAJANDO sweep and registers the next target floor.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   bus (slave) : buttons, car status in; pendientes, piso_objetivo,
//                 objetivo_valido, sentido_barrido out
//   atenciones [8] : served-call counter, only with CONTADOR_ATENCIONES_EN defined
module gestor_llamadas_asc
  import asc_pkg::*;
#(
  parameter int N_PISOS = N_PISOS_DEF,
  parameter int W_PISO  = W_PISO_DEF
) (
  input  logic clk,
  input  logic rst_n,
`ifdef CONTADOR_ATENCIONES_EN
  output logic [7:0] atenciones,
`endif
  gestor_llamadas_asc_if.slave bus
);

  // Top floor has no "up" button, ground floor has no "down" button
  localparam logic [N_PISOS-1:0] MASK_SUB = {1'b0, {(N_PISOS-1){1'b1}}};
  localparam logic [N_PISOS-1:0] MASK_BAJ = {{(N_PISOS-1){1'b1}}, 1'b0};

  logic [N_PISOS-1:0] ev_cab, ev_sub, ev_baj;
  logic [N_PISOS-1:0] cab_q, sub_q, baj_q;
  logic [N_PISOS-1:0] cab_d, sub_d, baj_d;
  logic [N_PISOS-1:0] pend, pend_eff, clr;
  logic               above, below, here;
  int                 piso_i;
  logic               piso_ok;

  barrido_e           estado_q, estado_d;
  logic [W_PISO-1:0]  obj_q, obj_d;
  logic               valido_q, valido_d;

  // direccion is advisory: the sweep is driven purely by pending calls
  logic [1:0]         unused_dir;
  assign unused_dir = (bus.direccion == 2'b11) ? DIR_PARADO : bus.direccion;

  detector_flanco_asc #(.N(N_PISOS)) u_det_cab (
    .clk(clk), .rst_n(rst_n), .d(bus.boton_cabina), .flanco(ev_cab)
  );
  detector_flanco_asc #(.N(N_PISOS)) u_det_sub (
    .clk(clk), .rst_n(rst_n), .d(bus.boton_subir), .flanco(ev_sub)
  );
  detector_flanco_asc #(.N(N_PISOS)) u_det_baj (
    .clk(clk), .rst_n(rst_n), .d(bus.boton_bajar), .flanco(ev_baj)
  );

  assign piso_i  = int'(bus.piso);
  assign piso_ok = (piso_i < N_PISOS);

  // Open doors at a valid floor serve every call there, including a press
  // arriving in the same cycle
  always_comb begin
    clr = '0;
    if (bus.puertas_abiertas && piso_ok) begin
      clr[bus.piso] = 1'b1;
    end
  end

  assign cab_d = (cab_q | ev_cab) & ~clr;
  assign sub_d = (sub_q | (ev_sub & MASK_SUB)) & ~clr;
  assign baj_d = (baj_q | (ev_baj & MASK_BAJ)) & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cab_q <= '0;
      sub_q <= '0;
      baj_q <= '0;
    end else begin
      cab_q <= cab_d;
      sub_q <= sub_d;
      baj_q <= baj_d;
    end
  end

  assign pend     = cab_q | sub_q | baj_q;
  // The floor being served is never a candidate for the sweep
  assign pend_eff = pend & ~clr;

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    here  = 1'b0;
    for (int i = 0; i < N_PISOS; i++) begin
      if (pend_eff[i]) begin
        if (i > piso_i) above = 1'b1;
        if (i < piso_i) below = 1'b1;
        if (i == piso_i) here = 1'b1;
      end
    end
  end

  // Sweep next-state
  always_comb begin
    estado_d = estado_q;
    if (piso_ok) begin
      case (estado_q)
        REPOSO: begin
          if (above)      estado_d = SUBIENDO;
          else if (below) estado_d = BAJANDO;
        end
        SUBIENDO: begin
          if (above || here) estado_d = SUBIENDO;
          else if (below)    estado_d = BAJANDO;
          else               estado_d = REPOSO;
        end
        BAJANDO: begin
          if (below || here) estado_d = BAJANDO;
          else if (above)    estado_d = SUBIENDO;
          else               estado_d = REPOSO;
        end
        default: estado_d = REPOSO;
      endcase
    end
  end

  // Target follows the direction the sweep is about to take
  always_comb begin
    obj_d    = obj_q;
    valido_d = 1'b0;
    if (piso_ok) begin
      case (estado_d)
        SUBIENDO: begin
          for (int i = N_PISOS - 1; i >= 0; i--) begin
            if (pend_eff[i] && (i >= piso_i)) begin
              obj_d    = W_PISO'(i);
              valido_d = 1'b1;
            end
          end
        end
        BAJANDO: begin
          for (int i = 0; i < N_PISOS; i++) begin
            if (pend_eff[i] && (i <= piso_i)) begin
              obj_d    = W_PISO'(i);
              valido_d = 1'b1;
            end
          end
        end
        default: begin
          if (here) begin
            obj_d    = bus.piso;
            valido_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= REPOSO;
      obj_q    <= '0;
      valido_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      obj_q    <= obj_d;
      valido_q <= valido_d;
    end
  end

  assign bus.pendientes      = pend;
  assign bus.piso_objetivo   = obj_q;
  assign bus.objetivo_valido = valido_q;
  assign bus.sentido_barrido = estado_q;

`ifdef CONTADOR_ATENCIONES_EN
  logic servicio;
  assign servicio = bus.puertas_abiertas && piso_ok && pend[bus.piso];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      atenciones <= 8'd0;
    end else if (servicio) begin
      atenciones <= atenciones + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gestor_llamadas_asc.sv
// tb/tb_gestor_llamadas_asc.sv - directed self-checking bench for gestor_llamadas_asc
// Purpose: drives directed button/car-status steps and checks against hand-computed values.
// Ports: none (top-level bench).
module tb_gestor_llamadas_asc;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  gestor_llamadas_asc_if #(.N_PISOS(4), .W_PISO(2)) bus_if ();

`ifdef CONTADOR_ATENCIONES_EN
  logic [7:0] atenciones;
`endif

  gestor_llamadas_asc #(.N_PISOS(4), .W_PISO(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef CONTADOR_ATENCIONES_EN
    .atenciones(atenciones),
`endif
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

`ifdef CONTADOR_ATENCIONES_EN
  task automatic serve_one(input int f);
    bus_if.piso = 2'd0;
    bus_if.puertas_abiertas = 1'b0;
    bus_if.boton_cabina = 4'(1 << f);
    tick();
    tick();
    bus_if.boton_cabina = 4'b0000;
    tick();
    bus_if.piso = 2'(f);
    bus_if.puertas_abiertas = 1'b1;
    tick();
    bus_if.puertas_abiertas = 1'b0;
    bus_if.piso = 2'd0;
  endtask
`endif

  initial begin
    passed = 0;
    total  = 0;
    rst_n = 1'b0;
    bus_if.boton_cabina = 4'b1111;
    bus_if.boton_subir  = 4'b1111;
    bus_if.boton_bajar  = 4'b1111;
    bus_if.piso = 2'd0;
    bus_if.direccion = 2'b00;
    bus_if.puertas_abiertas = 1'b0;

    // Reset with buttons held
    tick();
    tick();
    check("rst_pend", 32'(bus_if.pendientes), 32'h0);
    check("rst_valid", 32'(bus_if.objetivo_valido), 32'h0);
    check("rst_obj", 32'(bus_if.piso_objetivo), 32'h0);
    check("rst_sweep", 32'(bus_if.sentido_barrido), 32'h0);
    bus_if.boton_cabina = 4'b0000;
    bus_if.boton_subir  = 4'b0000;
    bus_if.boton_bajar  = 4'b0000;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("idle_valid", 32'(bus_if.objetivo_valido), 32'h0);

    // Nonexistent buttons: down at ground floor, up at top floor
    bus_if.boton_bajar = 4'b0001;
    bus_if.boton_subir = 4'b1000;
    bus_if.direccion = 2'b11;
    tick();
    tick();
    tick();
    check("ign_pend", 32'(bus_if.pendientes), 32'h0);
    check("ign_valid", 32'(bus_if.objetivo_valido), 32'h0);
    bus_if.boton_bajar = 4'b0000;
    bus_if.boton_subir = 4'b0000;
    bus_if.direccion = 2'b00;
    tick();

    // Cabin call to floor 2 from floor 0, held for 3 cycles
    bus_if.boton_cabina = 4'b0100;
    tick();
    check("lat_pend0", 32'(bus_if.pendientes), 32'h0);
    tick();
    check("lat_pend1", 32'(bus_if.pendientes), 32'h4);
    check("lat_valid1", 32'(bus_if.objetivo_valido), 32'h0);
    tick();
    check("up_sweep", 32'(bus_if.sentido_barrido), 32'h1);
    check("up_obj", 32'(bus_if.piso_objetivo), 32'h2);
    check("up_valid", 32'(bus_if.objetivo_valido), 32'h1);
    bus_if.boton_cabina = 4'b0000;
    tick();
    tick();
    check("hold_pend", 32'(bus_if.pendientes), 32'h4);

    // Serve floor 2: sweep idles, target holds last value
    bus_if.piso = 2'd2;
    bus_if.puertas_abiertas = 1'b1;
    tick();
    check("srv2_pend", 32'(bus_if.pendientes), 32'h0);
    check("srv2_sweep", 32'(bus_if.sentido_barrido), 32'h0);
    check("srv2_valid", 32'(bus_if.objetivo_valido), 32'h0);
    check("srv2_obj", 32'(bus_if.piso_objetivo), 32'h2);
    bus_if.puertas_abiertas = 1'b0;

    // At floor 1: cab[3] and sub[0]; direccion mismatch is ignored
    bus_if.piso = 2'd1;
    bus_if.direccion = 2'b10;
    bus_if.boton_cabina = 4'b1000;
    bus_if.boton_subir  = 4'b0001;
    tick();
    tick();
    check("f1_pend", 32'(bus_if.pendientes), 32'h9);
    tick();
    check("f1_sweep", 32'(bus_if.sentido_barrido), 32'h1);
    check("f1_obj", 32'(bus_if.piso_objetivo), 32'h3);
    bus_if.boton_cabina = 4'b0000;
    bus_if.boton_subir  = 4'b0000;
    bus_if.direccion = 2'b00;

    // Arrive at 3 with doors open: reverse towards 0
    bus_if.piso = 2'd3;
    bus_if.puertas_abiertas = 1'b1;
    tick();
    check("f3_pend", 32'(bus_if.pendientes), 32'h1);
    check("f3_sweep", 32'(bus_if.sentido_barrido), 32'h2);
    check("f3_obj", 32'(bus_if.piso_objetivo), 32'h0);
    check("f3_valid", 32'(bus_if.objetivo_valido), 32'h1);

    // Doors open at 2: press there is served at once, press at 0 unaffected
    bus_if.piso = 2'd2;
    bus_if.boton_subir  = 4'b0100;
    bus_if.boton_cabina = 4'b0001;
    tick();
    check("clr_pend0", 32'(bus_if.pendientes), 32'h1);
    tick();
    check("clr_pend1", 32'(bus_if.pendientes), 32'h1);
    tick();
    check("clr_pend2", 32'(bus_if.pendientes), 32'h1);
    bus_if.boton_subir  = 4'b0000;
    bus_if.boton_cabina = 4'b0000;
    bus_if.puertas_abiertas = 1'b0;
    tick();
    check("clr_pend3", 32'(bus_if.pendientes), 32'h1);
    check("clr_sweep", 32'(bus_if.sentido_barrido), 32'h2);
    check("clr_obj", 32'(bus_if.piso_objetivo), 32'h0);

    // Async reset mid-sweep with calls pending
    bus_if.boton_cabina = 4'b1000;
    bus_if.boton_subir  = 4'b0010;
    tick();
    tick();
    check("mid_pend", 32'(bus_if.pendientes), 32'hB);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pend", 32'(bus_if.pendientes), 32'h0);
    check("arst_sweep", 32'(bus_if.sentido_barrido), 32'h0);
    check("arst_valid", 32'(bus_if.objetivo_valido), 32'h0);
    check("arst_obj", 32'(bus_if.piso_objetivo), 32'h0);
    bus_if.boton_cabina = 4'b0000;
    bus_if.boton_subir  = 4'b0000;
    tick();
    rst_n = 1'b1;
    tick();

`ifdef CONTADOR_ATENCIONES_EN
    check("cnt_rst", 32'(atenciones), 32'h0);
    serve_one(1);
    serve_one(2);
    serve_one(3);
    check("cnt_3", 32'(atenciones), 32'h3);
    for (int k = 0; k < 253; k++) begin
      serve_one(1);
    end
    check("cnt_wrap", 32'(atenciones), 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
